// File: rtl/gtxe2_oob_ctrl.sv
// SATA-style OOB handshake controller for a GTXE2 transceiver.
// Sequences COMINIT/COMWAKE, comma alignment and retries on timeout.
module gtxe2_oob_ctrl #(
  parameter int TIMEOUT_CYCLES = 880000,
  parameter int RETRY_MAX      = 4,
  parameter int TIMER_W        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cplllock,
  input  logic       txcomfinish,
  input  logic       rxcominitdet,
  input  logic       rxcomwakedet,
  input  logic       rxelecidle,
  input  logic       rxbyteisaligned,
  output logic       txcominit,
  output logic       txcomwake,
  output logic       txelecidle,
  output logic       rxcommaalignen,
  output logic       link_up,
  output logic       busy,
  output logic       fail,
  output logic [2:0] state
);

  localparam int RW = $clog2(RETRY_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_INIT = 3'd1;
  localparam logic [2:0] S_WAIT_INIT = 3'd2;
  localparam logic [2:0] S_SEND_WAKE = 3'd3;
  localparam logic [2:0] S_WAIT_WAKE = 3'd4;
  localparam logic [2:0] S_ALIGN     = 3'd5;
  localparam logic [2:0] S_LINK      = 3'd6;
  localparam logic [2:0] S_FAIL      = 3'd7;

  logic [2:0]         cur;
  logic [2:0]         nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic [RW-1:0]      retry;
  logic [RW-1:0]      retry_nxt;
  logic               tmo;
  logic               retry_hit;

  assign tmo       = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign retry_hit = ((retry + RW'(1)) == RW'(RETRY_MAX));
  assign state     = cur;

  always_comb begin
    nxt       = cur;
    retry_nxt = retry;
    timer_nxt = (&timer) ? timer : timer + TIMER_W'(1);
    unique case (cur)
      S_IDLE, S_FAIL: begin
        if (start && cplllock) begin
          nxt       = S_SEND_INIT;
          retry_nxt = '0;
        end
      end
      S_SEND_INIT: begin
        // finish is only honoured after the pulse cycle
        if (txcomfinish && !txcominit) begin
          nxt       = S_WAIT_INIT;
          timer_nxt = '0;
        end
      end
      S_WAIT_INIT: begin
        if (rxcominitdet) begin
          nxt = S_SEND_WAKE;
        end else if (tmo) begin
          retry_nxt = retry + RW'(1);
          nxt       = retry_hit ? S_FAIL : S_SEND_INIT;
        end
      end
      S_SEND_WAKE: begin
        if (txcomfinish && !txcomwake) begin
          nxt       = S_WAIT_WAKE;
          timer_nxt = '0;
        end
      end
      S_WAIT_WAKE: begin
        if (rxcomwakedet) begin
          nxt       = S_ALIGN;
          timer_nxt = '0;
        end else if (tmo) begin
          retry_nxt = retry + RW'(1);
          nxt       = retry_hit ? S_FAIL : S_SEND_INIT;
        end
      end
      S_ALIGN: begin
        if (rxbyteisaligned && !rxelecidle) begin
          nxt = S_LINK;
        end else if (tmo) begin
          retry_nxt = retry + RW'(1);
          nxt       = retry_hit ? S_FAIL : S_SEND_INIT;
        end
      end
      S_LINK: begin
        if (rxcominitdet) begin
          nxt       = S_SEND_INIT;
          retry_nxt = '0;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // losing the PLL aborts any active sequence
    if (!cplllock && cur != S_IDLE && cur != S_FAIL) begin
      nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur            <= S_IDLE;
      timer          <= '0;
      retry          <= '0;
      txcominit      <= 1'b0;
      txcomwake      <= 1'b0;
      txelecidle     <= 1'b1;
      rxcommaalignen <= 1'b0;
      link_up        <= 1'b0;
      busy           <= 1'b0;
      fail           <= 1'b0;
    end else begin
      cur            <= nxt;
      timer          <= timer_nxt;
      retry          <= retry_nxt;
      txcominit      <= (nxt == S_SEND_INIT) && (cur != S_SEND_INIT);
      txcomwake      <= (nxt == S_SEND_WAKE) && (cur != S_SEND_WAKE);
      txelecidle     <= !((nxt == S_ALIGN) || (nxt == S_LINK));
      rxcommaalignen <= (nxt == S_ALIGN);
      link_up        <= (nxt == S_LINK);
      busy           <= (nxt >= S_SEND_INIT) && (nxt <= S_ALIGN);
      fail           <= (nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_gtxe2_oob_ctrl.sv
// Scoreboard bench for gtxe2_oob_ctrl: expected state/output records
// are queued by the stimulus and checked by a monitor on each state change.
module tb_gtxe2_oob_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cplllock = 1'b1;
  logic       txcomfinish = 1'b0;
  logic       rxcominitdet = 1'b0;
  logic       rxcomwakedet = 1'b0;
  logic       rxelecidle = 1'b1;
  logic       rxbyteisaligned = 1'b0;
  logic       txcominit;
  logic       txcomwake;
  logic       txelecidle;
  logic       rxcommaalignen;
  logic       link_up;
  logic       busy;
  logic       fail;
  logic [2:0] state;

  gtxe2_oob_ctrl #(
    .TIMEOUT_CYCLES(100),
    .RETRY_MAX(4),
    .TIMER_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cplllock(cplllock),
    .txcomfinish(txcomfinish),
    .rxcominitdet(rxcominitdet),
    .rxcomwakedet(rxcomwakedet),
    .rxelecidle(rxelecidle),
    .rxbyteisaligned(rxbyteisaligned),
    .txcominit(txcominit),
    .txcomwake(txcomwake),
    .txelecidle(txelecidle),
    .rxcommaalignen(rxcommaalignen),
    .link_up(link_up),
    .busy(busy),
    .fail(fail),
    .state(state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ini_cnt = 0;
  int          wak_cnt = 0;
  int          last_pulse = -1;
  int          pulse_gap = 0;
  int          i0;
  int          w0;
  bit          mon_en = 1'b0;
  logic [2:0]  prev;
  logic [9:0]  e;
  logic [9:0]  exp_q[$];

  always @(posedge clk) cyc++;

  function automatic logic [9:0] exp_of(input logic [2:0] s);
    return {s, s == 3'd1, s == 3'd3, !(s == 3'd5 || s == 3'd6),
            s == 3'd5, s == 3'd6, (s >= 3'd1 && s <= 3'd5), s == 3'd7};
  endfunction

  function automatic logic [9:0] obs();
    return {state, txcominit, txcomwake, txelecidle,
            rxcommaalignen, link_up, busy, fail};
  endfunction

  task automatic expect_st(input logic [2:0] s);
    exp_q.push_back(exp_of(s));
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // called in the first cycle of a SEND state
  task automatic send_phase();
    tick(5);
    txcomfinish = 1'b1;
    tick(1);
    txcomfinish = 1'b0;
  endtask

  task automatic run_to_link();
    expect_st(3'd2);
    send_phase();
    tick(20);
    rxcominitdet = 1'b1;
    expect_st(3'd3);
    tick(1);
    rxcominitdet = 1'b0;
    expect_st(3'd4);
    send_phase();
    tick(20);
    rxcomwakedet = 1'b1;
    expect_st(3'd5);
    tick(1);
    rxcomwakedet = 1'b0;
    rxelecidle = 1'b0;
    tick(10);
    rxbyteisaligned = 1'b1;
    expect_st(3'd6);
    tick(1);
    rxbyteisaligned = 1'b0;
  endtask

  // n silent attempts from SEND_INIT; the last one ends in FAIL
  task automatic silent(input int n);
    for (int i = 0; i < n; i++) begin
      expect_st(3'd2);
      send_phase();
      expect_st((i == n - 1) ? 3'd7 : 3'd1);
      tick(100);
    end
  endtask

  task automatic do_start();
    expect_st(3'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (txcominit) begin
        ini_cnt++;
        if (last_pulse >= 0) pulse_gap = cyc - last_pulse;
        last_pulse = cyc;
      end
      if (txcomwake) wak_cnt++;
      if (state != prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_transition got=%b want=none", obs());
        end else begin
          e = exp_q.pop_front();
          if (obs() !== e) begin
            bad++;
            $display("FAIL transition got=%b want=%b", obs(), e);
          end
        end
      end
      prev = state;
    end
  end

  initial begin
    tick(3);
    chk("reset_vals", int'(obs()), int'(exp_of(3'd0)));
    prev   = state;
    mon_en = 1'b1;
    reset  = 1'b0;
    tick(2);
    chk("idle_hold", int'(state), 0);

    cplllock = 1'b0;
    start    = 1'b1;
    tick(2);
    start    = 1'b0;
    cplllock = 1'b1;
    tick(1);
    chk("start_nolock", int'(state), 0);

    // happy path
    i0 = ini_cnt;
    w0 = wak_cnt;
    do_start();
    run_to_link();
    tick(2);
    chk("happy_link_up", int'(link_up), 1);
    chk("happy_init_pulses", ini_cnt - i0, 1);
    chk("happy_wake_pulses", wak_cnt - w0, 1);

    // reinit with one earlier retry, then a silent device
    rxcominitdet = 1'b1;
    expect_st(3'd1);
    tick(1);
    rxcominitdet = 1'b0;
    expect_st(3'd2);
    send_phase();
    expect_st(3'd1);
    tick(100);
    run_to_link();
    tick(2);
    i0 = ini_cnt;
    rxcominitdet = 1'b1;
    expect_st(3'd1);
    tick(1);
    rxcominitdet = 1'b0;
    silent(4);
    chk("silent_pulses", ini_cnt - i0, 4);
    chk("silent_gap", pulse_gap, 106);
    chk("silent_fail", int'(fail), 1);
    chk("silent_busy", int'(busy), 0);
    tick(5);
    chk("fail_hold", int'(state), 7);

    // detect on the timeout cycle wins and keeps the retry count
    do_start();
    expect_st(3'd2);
    send_phase();
    tick(99);
    rxcominitdet = 1'b1;
    expect_st(3'd3);
    tick(1);
    rxcominitdet = 1'b0;
    chk("race_state", int'(state), 3);
    expect_st(3'd4);
    send_phase();
    expect_st(3'd1);
    tick(100);
    silent(3);
    chk("race_retry_fail", int'(state), 7);

    // lock loss in WAIT_WAKE
    do_start();
    expect_st(3'd2);
    send_phase();
    tick(3);
    rxcominitdet = 1'b1;
    expect_st(3'd3);
    tick(1);
    rxcominitdet = 1'b0;
    expect_st(3'd4);
    send_phase();
    tick(5);
    cplllock = 1'b0;
    expect_st(3'd0);
    tick(1);
    chk("lock_loss_elecidle", int'(txelecidle), 1);
    cplllock = 1'b1;
    tick(10);
    chk("no_autorestart", int'(state), 0);

    // reset in ALIGN; misaligned-while-idle must not reach LINK
    do_start();
    expect_st(3'd2);
    send_phase();
    tick(5);
    rxcominitdet = 1'b1;
    expect_st(3'd3);
    tick(1);
    rxcominitdet = 1'b0;
    expect_st(3'd4);
    send_phase();
    tick(5);
    rxcomwakedet = 1'b1;
    rxelecidle = 1'b1;
    expect_st(3'd5);
    tick(1);
    rxcomwakedet = 1'b0;
    rxbyteisaligned = 1'b1;
    tick(3);
    chk("align_comma_en", int'(rxcommaalignen), 1);
    reset = 1'b1;
    start = 1'b1;
    expect_st(3'd0);
    tick(1);
    chk("midreset_vals", int'(obs()), int'(exp_of(3'd0)));
    reset = 1'b0;
    start = 1'b0;
    rxbyteisaligned = 1'b0;
    tick(3);
    chk("post_reset_idle", int'(state), 0);

    tick(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
